// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-read-port register file.
package regfile_pkg;

    typedef enum logic {
        StClear,
        StIdle
    } rf_state_e;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefRegCount  = 32;
    localparam int unsigned DefAddrWidth = 5;
    localparam int unsigned DefNRead     = 2;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: range/zero check, write-through bypass and hold register.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DefDataWidth,
    parameter int unsigned REGCOUNT  = DefRegCount,
    parameter int unsigned ADDRWIDTH = DefAddrWidth,
    parameter bit          ZERO_REG  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          active,
    input  logic                          rd_en,
    input  logic [ADDRWIDTH-1:0]          rd_addr,
    input  logic                          wr_acc,
    input  logic [ADDRWIDTH-1:0]          wr_addr,
    input  logic [DATAWIDTH-1:0]          wr_data,
    input  logic [REGCOUNT*DATAWIDTH-1:0] mem_flat,
    output logic [DATAWIDTH-1:0]          rd_data
);

    localparam logic [ADDRWIDTH:0] RegCountW = (ADDRWIDTH+1)'(REGCOUNT);

    logic                 in_range;
    logic [DATAWIDTH-1:0] rd_val;
    logic [DATAWIDTH-1:0] rd_data_d, rd_data_q;

    assign in_range = ({1'b0, rd_addr} < RegCountW);

    always_comb begin
        rd_val = '0;
        if (!in_range || (ZERO_REG && (rd_addr == '0))) begin
            rd_val = '0;
        end else if (wr_acc && (wr_addr == rd_addr)) begin
            rd_val = wr_data;
        end else begin
            rd_val = mem_flat[int'(rd_addr) * DATAWIDTH +: DATAWIDTH];
        end
    end

    // Outputs are forced to zero for the whole clear sequence.
    always_comb begin
        rd_data_d = rd_data_q;
        if (!active) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write port and sequential clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DefDataWidth,
    parameter int unsigned REGCOUNT  = DefRegCount,
    parameter int unsigned ADDRWIDTH = DefAddrWidth,
    parameter int unsigned NREAD     = DefNRead,
    parameter bit          ZERO_REG  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    output logic                       ready,
    input  logic [NREAD-1:0]           rd_en,
    input  logic [NREAD*ADDRWIDTH-1:0] rd_addr,
    output logic [NREAD*DATAWIDTH-1:0] rd_data,
    input  logic                       wr_en,
    input  logic [ADDRWIDTH-1:0]       wr_addr,
    input  logic [DATAWIDTH-1:0]       wr_data
);

    localparam logic [ADDRWIDTH:0]   RegCountW = (ADDRWIDTH+1)'(REGCOUNT);
    localparam logic [ADDRWIDTH-1:0] LastIdx   = ADDRWIDTH'(REGCOUNT - 1);

    rf_state_e              state_d, state_q;
    logic [ADDRWIDTH-1:0]   cnt_d, cnt_q;
    logic [DATAWIDTH-1:0]   mem_d [REGCOUNT];
    logic [DATAWIDTH-1:0]   mem_q [REGCOUNT];
    logic [REGCOUNT*DATAWIDTH-1:0] mem_flat;
    logic                   active;
    logic                   wr_acc;

    assign active = (state_q == StIdle);
    assign ready  = active;

    assign wr_acc = active && wr_en && ({1'b0, wr_addr} < RegCountW)
                    && !(ZERO_REG && (wr_addr == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The array is not reset; the clear engine zeroes it after every reset.
    always_comb begin
        mem_d = mem_q;
        if (state_q == StClear) begin
            mem_d[cnt_q] = '0;
        end else if (wr_acc) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem_q <= mem_d;
        end
    end

    for (genvar i = 0; i < REGCOUNT; i++) begin : g_flat
        assign mem_flat[i*DATAWIDTH +: DATAWIDTH] = mem_q[i];
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rdport
        regfile_rdport #(
            .DATAWIDTH (DATAWIDTH),
            .REGCOUNT  (REGCOUNT),
            .ADDRWIDTH (ADDRWIDTH),
            .ZERO_REG  (ZERO_REG)
        ) u_rdport (
            .clk      (clk),
            .rst_n    (rst_n),
            .active   (active),
            .rd_en    (rd_en[p]),
            .rd_addr  (rd_addr[p*ADDRWIDTH +: ADDRWIDTH]),
            .wr_acc   (wr_acc),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .mem_flat (mem_flat),
            .rd_data  (rd_data[p*DATAWIDTH +: DATAWIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default instance (32 regs, zero reg) and a 20-reg instance without zero reg.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic        ready_a, ready_b;
    logic [63:0] rd_data_a, rd_data_b;

    int checks = 0;
    int errors = 0;

    regfile_mp #(
        .DATAWIDTH (32),
        .REGCOUNT  (32),
        .ADDRWIDTH (5),
        .NREAD     (2),
        .ZERO_REG  (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .ready   (ready_a),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data_a),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    regfile_mp #(
        .DATAWIDTH (32),
        .REGCOUNT  (20),
        .ADDRWIDTH (5),
        .NREAD     (2),
        .ZERO_REG  (1'b0)
    ) dut_nz (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .ready   (ready_b),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data_b),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr     = 1'b0;
        rd_en   = 2'b00;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    // After release, the 32-entry copy is ready after 32 edges, the 20-entry one after 20.
    task automatic check_clear_timing(input string tag);
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++;
            if (ready_a !== ((i >= 32) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s ready_a cycle %0d: got %b want %b", tag, i, ready_a, (i >= 32));
            end
            checks++;
            if (ready_b !== ((i >= 20) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s ready_b cycle %0d: got %b want %b", tag, i, ready_b, (i >= 20));
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b want 0/0", ready_a, ready_b);
        end
        checks++;
        if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h/%h want 0", rd_data_a, rd_data_b);
        end
        rst_n = 1'b1;
        check_clear_timing("reset");
        for (int a = 0; a < 32; a += 2) begin
            rd_en   = 2'b11;
            rd_addr = {5'(a + 1), 5'(a)};
            tick();
            checks++;
            if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
                errors++;
                $display("FAIL cleared_entries r%0d/r%0d: got %h/%h want 0", a, a + 1,
                         rd_data_a, rd_data_b);
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        tick();
        checks++;
        if (rd_data_a[31:0] !== 32'hDEADBEEF || rd_data_b[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read r5: got %h/%h want deadbeef", rd_data_a[31:0],
                     rd_data_b[31:0]);
        end
        checks++;
        if (rd_data_a[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL write_read port1_hold: got %h want 0", rd_data_a[63:32]);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
        tick();
        checks++;
        if (rd_data_a !== {2{32'h12345678}} || rd_data_b !== {2{32'h12345678}}) begin
            errors++;
            $display("FAIL bypass r7: got %h/%h want 1234567812345678", rd_data_a, rd_data_b);
        end
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b01; rd_addr = '0;
        tick();
        checks++;
        if (rd_data_a[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_on r0: got %h want 0", rd_data_a[31:0]);
        end
        checks++;
        if (rd_data_b[31:0] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL zero_reg_off r0: got %h want ffffffff", rd_data_b[31:0]);
        end
        idle_inputs();
    endtask

    task automatic test_range();
        wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b10; rd_addr = {5'd25, 5'd0};
        tick();
        checks++;
        if (rd_data_a[63:32] !== 32'h55 || rd_data_b[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL range r25: got %h/%h want 55/0", rd_data_a[63:32], rd_data_b[63:32]);
        end
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h66;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd31};
        tick();
        checks++;
        if (rd_data_a[31:0] !== 32'h66 || rd_data_b[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL range_bypass r31: got %h/%h want 66/0", rd_data_a[31:0],
                     rd_data_b[31:0]);
        end
        wr_en = 1'b1; wr_addr = 5'd19; wr_data = 32'h19;
        rd_en = 2'b00;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd19};
        tick();
        checks++;
        if (rd_data_a[31:0] !== 32'h19 || rd_data_b[31:0] !== 32'h19) begin
            errors++;
            $display("FAIL range_last r19: got %h/%h want 19/19", rd_data_a[31:0],
                     rd_data_b[31:0]);
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
        tick();
        checks++;
        if (rd_data_a[63:32] !== 32'hA5 || rd_data_b[63:32] !== 32'hA5) begin
            errors++;
            $display("FAIL hold_read r3: got %h/%h want a5", rd_data_a[63:32], rd_data_b[63:32]);
        end
        rd_en = 2'b00;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h5A;
        tick();
        wr_en = 1'b0;
        tick();
        checks++;
        if (rd_data_a[63:32] !== 32'hA5 || rd_data_b[63:32] !== 32'hA5) begin
            errors++;
            $display("FAIL hold_disabled r3: got %h/%h want a5", rd_data_a[63:32],
                     rd_data_b[63:32]);
        end
        rd_en = 2'b10;
        tick();
        checks++;
        if (rd_data_a[63:32] !== 32'h5A || rd_data_b[63:32] !== 32'h5A) begin
            errors++;
            $display("FAIL hold_reenable r3: got %h/%h want 5a", rd_data_a[63:32],
                     rd_data_b[63:32]);
        end
        idle_inputs();
    endtask

    task automatic test_clear_restart();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
        tick();
        checks++;
        if (rd_data_a[31:0] !== 32'h77 || rd_data_b[31:0] !== 32'h77) begin
            errors++;
            $display("FAIL clear_pre r9: got %h/%h want 77", rd_data_a[31:0], rd_data_b[31:0]);
        end
        rd_en = 2'b00;
        clr   = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready_fall: got %b/%b want 0/0", ready_a, ready_b);
        end
        // Reads and writes during the clear must be ignored and outputs forced to zero.
        rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hBAD;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
            errors++;
            $display("FAIL clear_rd_zero: got %h/%h want 0", rd_data_a, rd_data_b);
        end
        checks++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready_low: got %b/%b want 0/0", ready_a, ready_b);
        end
        idle_inputs();
        rst_n = 1'b0;
        clr   = 1'b1;
        tick();
        clr   = 1'b0;
        rst_n = 1'b1;
        check_clear_timing("restart");
        rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
        tick();
        checks++;
        if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
            errors++;
            $display("FAIL clear_post r9: got %h/%h want 0", rd_data_a, rd_data_b);
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_range();
        test_hold();
        test_clear_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file; successor to the 2-read/1-write integer register file in the RISC-V datapath. Adds configurable read-port count, per-port read enables with output hold, an optional hardwired-zero register, and a sequential clear engine. The clear engine runs after reset or on request and zeroes the array one entry per cycle. Sits between decode (read addresses) and writeback (write port); the `ready` output gates issue.

## Interface
- `DATAWIDTH`, 32, bits per register
- `REGCOUNT`, 32, number of registers, 2..256
- `ADDRWIDTH`, 5, address width; must satisfy 2^ADDRWIDTH >= REGCOUNT
- `NREAD`, 2, number of read ports, 1..4
- `ZERO_REG`, 1, 1 = register 0 reads as zero and ignores writes
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `clr`  in  1  pulse in IDLE starts a full clear
- `ready`  out  1  1 = array valid, reads/writes serviced
- `rd_en`  in  NREAD  per-port read enable
- `rd_addr`  in  NREAD*ADDRWIDTH  read addresses; port p at bits [p*ADDRWIDTH +: ADDRWIDTH]
- `rd_data`  out  NREAD*DATAWIDTH  registered read data; port p at bits [p*DATAWIDTH +: DATAWIDTH]
- `wr_en`  in  1  write enable
- `wr_addr`  in  ADDRWIDTH  write address
- `wr_data`  in  DATAWIDTH  write data

## Operation
- States: CLEAR, IDLE.
- Reset (`rst_n`=0 at an edge): state <= CLEAR, clear counter <= 0, `ready` <= 0, all `rd_data` <= 0.
- CLEAR: each cycle write 0 to entry[counter], then counter += 1. On the cycle counter == REGCOUNT-1, go to IDLE.
- CLEAR behaviour for other inputs: `wr_en` ignored (write dropped); `rd_en` ignored; `rd_data` held at 0; `clr` ignored.
- IDLE: `ready`=1. `clr`=1 enters CLEAR with counter 0, `ready` falls next edge; a write in that same cycle is performed, then erased by the clear.
- Write, IDLE only: `wr_en`=1 → entry[wr_addr] <= wr_data. Write is dropped if wr_addr >= REGCOUNT, or if ZERO_REG=1 and wr_addr == 0.
- Read port p, IDLE only: `rd_en[p]`=1 → rd_data[p] <= value. `rd_en[p]`=0 → rd_data[p] holds its previous value.
- Read value, in priority order:
  - 0 if ZERO_REG=1 and addr == 0, or if addr >= REGCOUNT.
  - Else wr_data if a write is accepted this cycle to the same address (write-through bypass).
  - Else entry[addr].
- All ports are independent; any number may read the same address in one cycle.

## Timing
- Read latency 1 cycle: address and enable sampled at edge N, data valid after edge N.
- Bypass is same-edge: a write and a read to address A at edge N give rd_data = new value after N.
- Clear takes exactly REGCOUNT cycles: after reset release at edge 0, `ready` rises after edge REGCOUNT.
- Reset mid-clear restarts the counter at 0. Reset overrides `clr` and `wr_en`.
- No combinational path from inputs to outputs.

## Structure
- Shared package `regfile_pkg`: state enum (CLEAR, IDLE) and default parameter constants (DATAWIDTH, REGCOUNT, NREAD).
- Sub-module `regfile_rdport`, one generate instance per read port. Each instance contains the address range check, zero check, bypass mux and hold register.
- Top level holds the array, write logic, clear FSM and counter.

## Test plan
- Reset, then idle 32 cycles with defaults → `ready`=0 for 32 cycles, then 1; every entry reads 0.
- Write 0xDEADBEEF to r5; next cycle read r5 on port 0 → 0xDEADBEEF one cycle after the read.
- Same-cycle write 0x12345678 to r7 and read r7 on both ports → both ports show 0x12345678 after that edge.
- ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 → 0. With ZERO_REG=0, the same sequence → 0xFFFFFFFF.
- Drop `rd_en[1]` after reading r3 = 0xA5, then write r3 = 0x5A → port 1 holds 0xA5 until re-enabled.
- Assert `clr` in IDLE with r9 = 0x77; at cycle 10 of the clear, pulse `rst_n` low → `ready` rises exactly 32 cycles after reset release, and r9 reads 0.
